acorn128_ctrl: RTL and testbench

ACORN128_CTRL -- requirements
Module: acorn128_ctrl

---
 rtl/acorn128_ctrl_if.sv | 36 +++
 rtl/acorn128_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_acorn128_ctrl.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/acorn128_ctrl_if.sv
// Bus bundle between the ACORN-128 controller and its environment: host
// request/length fields, serial AD/plaintext streams, datapath control and results.
interface acorn128_ctrl_if;
  logic         start;
  logic [127:0] key;
  logic [127:0] iv;
  logic [15:0]  ad_len;
  logic [15:0]  msg_len;
  logic         ad_bit;
  logic         ad_valid;
  logic         ad_ready;
  logic         pt_bit;
  logic         pt_valid;
  logic         pt_ready;
  logic         ks_in;
  logic         su_clr;
  logic         su_en;
  logic         ca;
  logic         cb;
  logic         mbit;
  logic         ct_bit;
  logic         ct_valid;
  logic [127:0] tag;
  logic         busy;
  logic         done;

  modport slave (
    input  start, key, iv, ad_len, msg_len, ad_bit, ad_valid, pt_bit, pt_valid, ks_in,
    output ad_ready, pt_ready, su_clr, su_en, ca, cb, mbit, ct_bit, ct_valid, tag, busy, done
  );

  modport master (
    output start, key, iv, ad_len, msg_len, ad_bit, ad_valid, pt_bit, pt_valid, ks_in,
    input  ad_ready, pt_ready, su_clr, su_en, ca, cb, mbit, ct_bit, ct_valid, tag, busy, done
  );
endinterface

// File: rtl/acorn128_ctrl.sv
// ACORN-128 sequencing controller: walks init / AD / message / finalisation phases,
// steering ca/cb/mbit into an external state-update datapath and collecting ct and tag.
module acorn128_ctrl (
  input  logic           clk,
  input  logic           rst,
  acorn128_ctrl_if.slave bus
);
  typedef enum logic [3:0] {
    IDLE, CLR, INIT_KEY, INIT_IV, INIT_MIX, AD, AD_PAD, MSG, MSG_PAD, FINAL
  } state_e;

  state_e       state_q, state_d;
  // Step counter j; the fixed phases only reach 1535, the upper bits exist so
  // AD/MSG can count the full 16-bit lengths.
  logic [15:0]  j_q, j_d;
  logic [127:0] key_q, key_d;
  logic [127:0] iv_q, iv_d;
  logic [15:0]  ad_len_q, ad_len_d;
  logic [15:0]  msg_len_q, msg_len_d;
  logic [127:0] tag_q, tag_d;
  logic         done_q, done_d;
  logic         ct_bit_q, ct_bit_d;
  logic         ct_valid_q, ct_valid_d;

  logic su_clr, su_en, ca, cb, mbit, ad_ready, pt_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      j_q        <= '0;
      key_q      <= '0;
      iv_q       <= '0;
      ad_len_q   <= '0;
      msg_len_q  <= '0;
      tag_q      <= '0;
      done_q     <= 1'b0;
      ct_bit_q   <= 1'b0;
      ct_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      j_q        <= j_d;
      key_q      <= key_d;
      iv_q       <= iv_d;
      ad_len_q   <= ad_len_d;
      msg_len_q  <= msg_len_d;
      tag_q      <= tag_d;
      done_q     <= done_d;
      ct_bit_q   <= ct_bit_d;
      ct_valid_q <= ct_valid_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    j_d        = j_q;
    key_d      = key_q;
    iv_d       = iv_q;
    ad_len_d   = ad_len_q;
    msg_len_d  = msg_len_q;
    tag_d      = tag_q;
    done_d     = done_q;
    ct_bit_d   = ct_bit_q;
    ct_valid_d = 1'b0;
    case (state_q)
      IDLE: if (bus.start) begin
        state_d   = CLR;
        j_d       = '0;
        key_d     = bus.key;
        iv_d      = bus.iv;
        ad_len_d  = bus.ad_len;
        msg_len_d = bus.msg_len;
        done_d    = 1'b0;
        tag_d     = '0;
      end
      CLR: begin
        state_d = INIT_KEY;
        j_d     = '0;
      end
      INIT_KEY: if (j_q == 16'd127) begin
        state_d = INIT_IV;
        j_d     = '0;
      end else j_d = j_q + 16'd1;
      INIT_IV: if (j_q == 16'd127) begin
        state_d = INIT_MIX;
        j_d     = '0;
      end else j_d = j_q + 16'd1;
      INIT_MIX: if (j_q == 16'd1535) begin
        state_d = (ad_len_q == '0) ? AD_PAD : AD;
        j_d     = '0;
      end else j_d = j_q + 16'd1;
      AD: if (bus.ad_valid) begin
        if (j_q == ad_len_q - 16'd1) begin
          state_d = AD_PAD;
          j_d     = '0;
        end else j_d = j_q + 16'd1;
      end
      AD_PAD: if (j_q == 16'd255) begin
        state_d = (msg_len_q == '0) ? MSG_PAD : MSG;
        j_d     = '0;
      end else j_d = j_q + 16'd1;
      MSG: if (bus.pt_valid) begin
        ct_bit_d   = bus.pt_bit ^ bus.ks_in;
        ct_valid_d = 1'b1;
        if (j_q == msg_len_q - 16'd1) begin
          state_d = MSG_PAD;
          j_d     = '0;
        end else j_d = j_q + 16'd1;
      end
      MSG_PAD: if (j_q == 16'd255) begin
        state_d = FINAL;
        j_d     = '0;
      end else j_d = j_q + 16'd1;
      FINAL: begin
        // 640 is a multiple of 128, so the tag index is just the low bits of j.
        if (j_q >= 16'd640) tag_d[j_q[6:0]] = bus.ks_in;
        if (j_q == 16'd767) begin
          state_d = IDLE;
          j_d     = '0;
          done_d  = 1'b1;
        end else j_d = j_q + 16'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    su_clr   = 1'b0;
    su_en    = 1'b0;
    ca       = 1'b0;
    cb       = 1'b0;
    mbit     = 1'b0;
    ad_ready = 1'b0;
    pt_ready = 1'b0;
    case (state_q)
      CLR: su_clr = 1'b1;
      INIT_KEY: begin
        su_en = 1'b1; ca = 1'b1; cb = 1'b1;
        mbit  = key_q[j_q[6:0]];
      end
      INIT_IV: begin
        su_en = 1'b1; ca = 1'b1; cb = 1'b1;
        mbit  = iv_q[j_q[6:0]];
      end
      INIT_MIX: begin
        su_en = 1'b1; ca = 1'b1; cb = 1'b1;
        mbit  = key_q[j_q[6:0]] ^ (j_q == '0);
      end
      AD: begin
        ad_ready = 1'b1;
        su_en    = bus.ad_valid;
        ca = 1'b1; cb = 1'b1;
        mbit     = bus.ad_bit;
      end
      AD_PAD: begin
        su_en = 1'b1; cb = 1'b1;
        ca    = (j_q < 16'd128);
        mbit  = (j_q == '0);
      end
      MSG: begin
        pt_ready = 1'b1;
        su_en    = bus.pt_valid;
        ca       = 1'b1;
        mbit     = bus.pt_bit;
      end
      MSG_PAD: begin
        su_en = 1'b1;
        ca    = (j_q < 16'd128);
        mbit  = (j_q == '0);
      end
      FINAL: begin
        su_en = 1'b1; ca = 1'b1; cb = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.su_clr   = su_clr;
  assign bus.su_en    = su_en;
  assign bus.ca       = ca;
  assign bus.cb       = cb;
  assign bus.mbit     = mbit;
  assign bus.ad_ready = ad_ready;
  assign bus.pt_ready = pt_ready;
  assign bus.ct_bit   = ct_bit_q;
  assign bus.ct_valid = ct_valid_q;
  assign bus.tag      = tag_q;
  assign bus.busy     = (state_q != IDLE);
  assign bus.done     = done_q;
endmodule

// File: tb/tb_acorn128_ctrl.sv
// Directed bench for acorn128_ctrl; a stub datapath supplies ks_in as a hash of the
// number of state-update steps since su_clr, so ct/tag expectations follow from step indices.
module tb_acorn128_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  acorn128_ctrl_if bus();
  acorn128_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

  int tests_run = 0;
  int tests_failed = 0;

  function automatic logic ks_fn(input int n);
    logic [31:0] h;
    h = 32'(n) * 32'h9E3779B1;
    return h[31] ^ h[17] ^ h[5];
  endfunction

  function automatic logic [127:0] exp_tag(input int base);
    logic [127:0] t;
    for (int i = 0; i < 128; i++) t[i] = ks_fn(base + i);
    return t;
  endfunction

  // Stub datapath and monitors
  int   steps = 0;
  int   sen_tot = 0, ad_rdy_tot = 0, pt_rdy_tot = 0, ct_tot = 0, stall_bad = 0, ad_idle = 0;
  logic mlog  [0:4095];
  logic calog [0:4095];
  logic cblog [0:4095];
  logic ct_log[0:4095];
  assign bus.ks_in = ks_fn(steps);

  always @(posedge clk) begin
    if (bus.su_clr) steps <= 0;
    else if (bus.su_en) begin
      steps <= steps + 1;
      if (steps < 4096) begin
        mlog[steps]  <= bus.mbit;
        calog[steps] <= bus.ca;
        cblog[steps] <= bus.cb;
      end
    end
    if (bus.su_en) sen_tot <= sen_tot + 1;
    if (bus.ad_ready) ad_rdy_tot <= ad_rdy_tot + 1;
    if (bus.pt_ready) pt_rdy_tot <= pt_rdy_tot + 1;
    if (bus.ad_ready && !bus.ad_valid) ad_idle <= ad_idle + 1;
    if (bus.ad_ready && !bus.ad_valid && bus.su_en) stall_bad <= stall_bad + 1;
    if (bus.ct_valid) begin
      if (ct_tot < 4096) ct_log[ct_tot] <= bus.ct_bit;
      ct_tot <= ct_tot + 1;
    end
  end

  // Stream drivers: bit index derived from the step count
  int           ad_mode = 1;
  int           cur_adl = 0;
  logic [127:0] ad_vec = 128'h000000000000000000000000000000A5;
  logic [127:0] pt_vec = 128'h0000000000000000000000000000003C;
  logic         ph = 1'b0;
  always @(negedge clk) begin
    ph           <= ~ph;
    bus.ad_valid <= (ad_mode == 1) || (ad_mode == 2 && ph);
    bus.ad_bit   <= ad_vec[7'(steps - 1792)];
    bus.pt_valid <= 1'b1;
    bus.pt_bit   <= pt_vec[7'(steps - 1792 - cur_adl - 256)];
  end

  localparam logic [127:0] K1 = 128'h0123456789ABCDEF_FEDCBA9876543211;
  localparam logic [127:0] V1 = 128'h00112233445566778899AABBCCDDEEFF;
  logic mref[0:4095];

  task automatic start_op(input logic [127:0] k, input logic [127:0] v, input int adl, input int ml);
    cur_adl = adl;
    @(negedge clk);
    bus.key = k; bus.iv = v; bus.ad_len = 16'(adl); bus.msg_len = 16'(ml); bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input int c0, output int c);
    c = c0;
    while (!bus.done && c < 8000) begin
      @(negedge clk);
      c++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    tests_run++;
    if ({bus.busy, bus.done, bus.su_en, bus.su_clr, bus.ad_ready, bus.pt_ready,
         bus.ct_valid, bus.ct_bit} !== 8'b0) begin
      tests_failed++;
      $display("FAIL reset_ctrl: got %b want 00000000", {bus.busy, bus.done, bus.su_en,
               bus.su_clr, bus.ad_ready, bus.pt_ready, bus.ct_valid, bus.ct_bit});
    end
    tests_run++;
    if (bus.tag !== 128'b0) begin
      tests_failed++;
      $display("FAIL reset_tag: got %h want 0", bus.tag);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_zero_len();
    int c, s0;
    s0 = sen_tot;
    start_op('0, '0, 0, 0);
    tests_run++;
    if (bus.busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL zero_busy: got %b want 1", bus.busy);
    end
    wait_done(0, c);
    tests_run++;
    if (c != 3073) begin
      tests_failed++;
      $display("FAIL zero_latency: got %0d want 3073", c);
    end
    tests_run++;
    if (sen_tot - s0 != 3072) begin
      tests_failed++;
      $display("FAIL zero_su_en_count: got %0d want 3072", sen_tot - s0);
    end
    tests_run++;
    if (bus.tag !== exp_tag(2944)) begin
      tests_failed++;
      $display("FAIL zero_tag: got %h want %h", bus.tag, exp_tag(2944));
    end
    repeat (3) @(negedge clk);
    tests_run++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL zero_done_hold: got done=%b busy=%b want done=1 busy=0", bus.done, bus.busy);
    end
  endtask

  task automatic test_ad_msg();
    int c, a0, p0, t0, bad, cbn, can;
    logic [127:0] kv;
    logic [7:0] ct_got, ct_exp, ad_got;
    kv = K1;
    a0 = ad_rdy_tot; p0 = pt_rdy_tot; t0 = ct_tot;
    ad_mode = 1;
    start_op(K1, V1, 8, 8);
    wait_done(0, c);
    tests_run++;
    if (c != 3089) begin
      tests_failed++;
      $display("FAIL admsg_latency: got %0d want 3089", c);
    end
    tests_run++;
    if (ad_rdy_tot - a0 != 8 || pt_rdy_tot - p0 != 8 || ct_tot - t0 != 8) begin
      tests_failed++;
      $display("FAIL admsg_counts: got ad_rdy=%0d pt_rdy=%0d ct=%0d want 8 8 8",
               ad_rdy_tot - a0, pt_rdy_tot - p0, ct_tot - t0);
    end
    for (int i = 0; i < 8; i++) begin
      ct_got[i] = ct_log[t0 + i];
      ct_exp[i] = pt_vec[i] ^ ks_fn(2056 + i);
      ad_got[i] = mlog[1792 + i];
    end
    tests_run++;
    if (ct_got !== ct_exp) begin
      tests_failed++;
      $display("FAIL admsg_ct: got %b want %b", ct_got, ct_exp);
    end
    tests_run++;
    if (ad_got !== 8'hA5) begin
      tests_failed++;
      $display("FAIL admsg_ad_mbits: got %h want a5", ad_got);
    end
    tests_run++;
    if (bus.tag !== exp_tag(2960)) begin
      tests_failed++;
      $display("FAIL admsg_tag: got %h want %h", bus.tag, exp_tag(2960));
    end
    bad = 0;
    for (int i = 0; i < 128; i++) if (mlog[i] !== kv[i]) bad++;
    tests_run++;
    if (bad != 0) begin
      tests_failed++;
      $display("FAIL init_key_mbits: got %0d wrong bits want 0", bad);
    end
    tests_run++;
    if (mlog[256] !== ~kv[0] || mlog[257] !== kv[1] || mlog[384] !== kv[0]) begin
      tests_failed++;
      $display("FAIL mix_mbit: got j0=%b j1=%b j128=%b want %b %b %b",
               mlog[256], mlog[257], mlog[384], ~kv[0], kv[1], kv[0]);
    end
    tests_run++;
    if (mlog[1800] !== 1'b1 || mlog[1801] !== 1'b0 || calog[1927] !== 1'b1 ||
        calog[1928] !== 1'b0 || cblog[1928] !== 1'b1) begin
      tests_failed++;
      $display("FAIL adpad_ctrl: got m0=%b m1=%b ca127=%b ca128=%b cb128=%b want 1 0 1 0 1",
               mlog[1800], mlog[1801], calog[1927], calog[1928], cblog[1928]);
    end
    cbn = 0; can = 0;
    for (int i = 2056; i < 2320; i++) if (cblog[i] !== 1'b0) cbn++;
    for (int i = 2064; i < 2320; i++) if (calog[i] === 1'b1) can++;
    tests_run++;
    if (cbn != 0 || can != 128 || mlog[2064] !== 1'b1) begin
      tests_failed++;
      $display("FAIL msgpad_ctrl: got cb_ones=%0d ca_ones=%0d m0=%b want 0 128 1", cbn, can, mlog[2064]);
    end
    for (int i = 0; i < 4096; i++) mref[i] = mlog[i];
  endtask

  task automatic test_ad_stall();
    int c, s0, i0, bad;
    s0 = sen_tot; i0 = ad_idle;
    ad_mode = 2;
    start_op(K1, V1, 8, 8);
    wait_done(0, c);
    ad_mode = 1;
    tests_run++;
    if (ad_idle - i0 == 0 || stall_bad != 0) begin
      tests_failed++;
      $display("FAIL stall_su_en: got idle=%0d bad=%0d want idle>0 bad=0", ad_idle - i0, stall_bad);
    end
    tests_run++;
    if (sen_tot - s0 != 3088 || c < 3090 || c > 3110) begin
      tests_failed++;
      $display("FAIL stall_steps: got su_en=%0d cycles=%0d want 3088 and 3090..3110", sen_tot - s0, c);
    end
    bad = 0;
    for (int i = 0; i < 3088; i++) if (mlog[i] !== mref[i]) bad++;
    tests_run++;
    if (bad != 0 || bus.tag !== exp_tag(2960)) begin
      tests_failed++;
      $display("FAIL stall_same_run: got mbit_diffs=%0d tag=%h want 0 %h", bad, bus.tag, exp_tag(2960));
    end
  endtask

  task automatic test_start_ignored();
    int c, s0;
    logic [127:0] kv;
    kv = K1;
    s0 = sen_tot;
    start_op(K1, V1, 0, 0);
    repeat (400) @(negedge clk);
    bus.key = ~K1; bus.ad_len = 16'd5; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(401, c);
    tests_run++;
    if (c != 3073 || sen_tot - s0 != 3072) begin
      tests_failed++;
      $display("FAIL start_ignored_counts: got cycles=%0d su_en=%0d want 3073 3072", c, sen_tot - s0);
    end
    tests_run++;
    if (mlog[256 + 500] !== kv[500 % 128] || bus.tag !== exp_tag(2944)) begin
      tests_failed++;
      $display("FAIL start_ignored_data: got m=%b tag=%h want %b %h",
               mlog[756], bus.tag, kv[500 % 128], exp_tag(2944));
    end
  endtask

  task automatic test_rst_mid();
    int c, s0, n;
    start_op(K1, V1, 8, 8);
    n = 0;
    while (!bus.pt_ready && n < 4000) begin
      @(negedge clk);
      n++;
    end
    tests_run++;
    if (bus.pt_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL rst_reach_msg: got pt_ready=%b want 1", bus.pt_ready);
    end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    tests_run++;
    if ({bus.busy, bus.done, bus.su_en, bus.su_clr, bus.ad_ready, bus.pt_ready,
         bus.ct_valid, bus.ct_bit} !== 8'b0 || bus.tag !== 128'b0) begin
      tests_failed++;
      $display("FAIL rst_mid_outputs: got %b tag=%h want 00000000 tag=0", {bus.busy, bus.done,
               bus.su_en, bus.su_clr, bus.ad_ready, bus.pt_ready, bus.ct_valid, bus.ct_bit}, bus.tag);
    end
    s0 = sen_tot;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    tests_run++;
    if (sen_tot != s0 || bus.busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL rst_mid_quiet: got su_en=%0d busy=%b want 0 0", sen_tot - s0, bus.busy);
    end
    s0 = sen_tot;
    start_op('0, '0, 0, 0);
    wait_done(0, c);
    tests_run++;
    if (c != 3073 || sen_tot - s0 != 3072 || bus.tag !== exp_tag(2944)) begin
      tests_failed++;
      $display("FAIL rst_restart: got cycles=%0d su_en=%0d tag=%h want 3073 3072 %h",
               c, sen_tot - s0, bus.tag, exp_tag(2944));
    end
  endtask

  initial begin
    bus.start = 1'b0; bus.key = '0; bus.iv = '0; bus.ad_len = '0; bus.msg_len = '0;
    test_reset();
    test_zero_len();
    test_ad_msg();
    test_ad_stall();
    test_start_ignored();
    test_rst_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
